// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and the
// byte-lane geometry used to pack a byte stream into 32-bit RAM words.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    GAP,
    FINISH
  } state_e;

  localparam int LANES  = 4;
  localparam int BYTE_W = 8;
  localparam int WORD_W = LANES * BYTE_W;
  localparam int LANE_W = $clog2(LANES);

endpackage

// File: rtl/byte_packer.sv
// Byte packer: assembles accepted stream bytes little-endian into a word.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   clear        restart packing at lane 0 (a new load begins)
//   accept       a byte transfer happens this cycle
//   byte_data    the byte being transferred
//   byte_last    the transferred byte is the final byte of the image
//   word         assembled word including the current byte (valid with word_valid)
//   word_valid   the current transfer closes a word (lane 3 or last byte)
//   last_seen    the closing transfer also carries byte_last
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              accept,
  input  logic [BYTE_W-1:0] byte_data,
  input  logic              byte_last,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic              last_seen
);

  logic [LANE_W-1:0] lane_q;
  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] word_d;

  // Lane 0 starts from an all-zero word, so a short final word comes out
  // zero-filled in its upper lanes without extra logic.
  always_comb begin
    word_d = (lane_q == '0) ? '0 : word_q;
    word_d[lane_q*BYTE_W +: BYTE_W] = byte_data;
  end

  assign word       = word_d;
  assign word_valid = accept && ((lane_q == LANE_W'(LANES - 1)) || byte_last);
  assign last_seen  = accept && byte_last;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lane_q <= '0;
      word_q <= '0;
    end else if (accept) begin
      word_q <= word_d;
      lane_q <= word_valid ? '0 : lane_q + LANE_W'(1);
    end
  end

endmodule

// File: rtl/program_loader.sv
// Program-image loader: takes a valid/ready byte stream, packs it into
// little-endian 32-bit words and writes them to consecutive word addresses
// of a basic_ram starting at BASE_ADDR, using the cs/we/oe + mem_done
// handshake. Words beyond MAX_WORDS are dropped and flag a sticky error.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start         begin a load (honoured only in IDLE or FINISH)
//   byte_valid    byte_data is valid this cycle
//   byte_data     stream byte
//   byte_last     marks the final byte of the image (with byte_valid)
//   byte_ready    loader accepts a byte this cycle
//   mem_address   RAM word address
//   mem_data_in   RAM write data
//   mem_cs        RAM chip select
//   mem_we        RAM write enable
//   mem_oe        RAM output enable, tied low
//   mem_done      RAM write complete
//   busy          a load is in progress
//   done          load finished, held until the next start or reset
//   error         capacity overflow during this load (sticky)
//   word_count    words written during this load
module program_loader
  import loader_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [WORD_W-1:0] mem_data_in,
  output logic              mem_cs,
  output logic              mem_we,
  output logic              mem_oe,
  input  logic              mem_done,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] word_count
);

  state_e            state_q;
  logic              byte_ready_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [WORD_W-1:0] mem_data_q;
  logic              mem_cs_q;
  logic              mem_we_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic [ADDR_W-1:0] word_count_q;
  logic              last_q;

  logic              accept;
  logic              clear;
  logic              at_capacity;
  logic [WORD_W-1:0] word;
  logic              word_valid;
  logic              last_seen;

  assign accept      = byte_valid && byte_ready_q;
  assign clear       = start && ((state_q == IDLE) || (state_q == FINISH));
  assign at_capacity = (word_count_q == ADDR_W'(MAX_WORDS));

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .accept     (accept),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .word       (word),
    .word_valid (word_valid),
    .last_seen  (last_seen)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      byte_ready_q  <= 1'b0;
      mem_address_q <= BASE_ADDR;
      mem_data_q    <= '0;
      mem_cs_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      word_count_q  <= '0;
      last_q        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, FINISH: begin
          if (start) begin
            state_q       <= COLLECT;
            byte_ready_q  <= 1'b1;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            word_count_q  <= '0;
            mem_address_q <= BASE_ADDR;
          end
        end
        COLLECT: begin
          if (word_valid) begin
            if (at_capacity) begin
              // Full: drop the word without touching the RAM and keep
              // draining the stream until the image ends.
              error_q <= 1'b1;
              if (last_seen) begin
                state_q      <= FINISH;
                byte_ready_q <= 1'b0;
                busy_q       <= 1'b0;
                done_q       <= 1'b1;
              end
            end else begin
              state_q      <= WRITE;
              byte_ready_q <= 1'b0;
              mem_data_q   <= word;
              last_q       <= last_seen;
              mem_cs_q     <= 1'b1;
              mem_we_q     <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (mem_done) begin
            state_q  <= GAP;
            mem_cs_q <= 1'b0;
            mem_we_q <= 1'b0;
          end
        end
        GAP: begin
          mem_address_q <= mem_address_q + ADDR_W'(1);
          word_count_q  <= word_count_q + ADDR_W'(1);
          if (last_q) begin
            state_q <= FINISH;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q      <= COLLECT;
            byte_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_ready  = byte_ready_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_q;
  assign mem_cs      = mem_cs_q;
  assign mem_we      = mem_we_q;
  assign mem_oe      = 1'b0;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign word_count  = word_count_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader. Three instances: default (0), MAX_WORDS=2 (1),
// BASE_ADDR=0x10 (2). Each has its own stream driver and a RAM responder
// whose mem_done latency is programmable per instance.
module tb_program_loader;

  localparam int ND = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start [ND];
  logic        bv    [ND];
  logic        bl    [ND];
  logic [7:0]  bd    [ND];
  logic        rdy   [ND];
  logic        cs    [ND];
  logic        we    [ND];
  logic        oe    [ND];
  logic        mdone [ND];
  logic        busy  [ND];
  logic        dn    [ND];
  logic        err   [ND];
  logic [31:0] addr  [ND];
  logic [31:0] wdata [ND];
  logic [31:0] wc    [ND];
  int          delay [ND];
  int          wcnt  [ND];

  logic [65:0] exp_q[$];
  logic [65:0] act_q[$];
  int          errors = 0;
  int          checks = 0;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    program_loader #(
      .ADDR_W    (32),
      .BASE_ADDR ((g == 2) ? 32'h10 : 32'h0),
      .MAX_WORDS ((g == 1) ? 2 : 1024)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start[g]),
      .byte_valid  (bv[g]),
      .byte_data   (bd[g]),
      .byte_last   (bl[g]),
      .byte_ready  (rdy[g]),
      .mem_address (addr[g]),
      .mem_data_in (wdata[g]),
      .mem_cs      (cs[g]),
      .mem_we      (we[g]),
      .mem_oe      (oe[g]),
      .mem_done    (mdone[g]),
      .busy        (busy[g]),
      .done        (dn[g]),
      .error       (err[g]),
      .word_count  (wc[g])
    );
  end

  // RAM responder: mem_done rises after 'delay' extra cycles of mem_we.
  always_comb begin
    for (int d = 0; d < ND; d++) mdone[d] = we[d] && (wcnt[d] >= delay[d]);
  end

  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      wcnt[d] <= we[d] ? wcnt[d] + 1 : 0;
      if (cs[d] && we[d] && mdone[d])
        act_q.push_back({2'(d), addr[d], wdata[d]});
    end
  end

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input int d, input logic [7:0] b, input logic last, input int gap);
    int n;
    bv[d] = 1'b1; bd[d] = b; bl[d] = last;
    n = 0;
    while (!rdy[d] && n < 200) begin @(negedge clk); n++; end
    chk("ready_wait", rdy[d], 1'b1);
    @(negedge clk);
    bv[d] = 1'b0; bl[d] = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_start(input int d);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  // Drives an image and pushes the RAM words it should produce.
  task automatic load(input int d, input logic [7:0] bytes[$], input logic [31:0] base,
                      input int maxw, input int gap, input int pulse_at);
    logic [31:0] word;
    int lane, nw;
    logic last;
    word = 0; lane = 0; nw = 0;
    for (int i = 0; i < bytes.size(); i++) begin
      if (i == pulse_at) begin
        do_start(d);
        chk("pulse_busy", busy[d], 1'b1);
      end
      if (lane == 0) word = 32'h0;
      word = word | (32'(bytes[i]) << (8 * lane));
      last = (i == bytes.size() - 1);
      if (lane == 3 || last) begin
        if (nw < maxw) exp_q.push_back({2'(d), base + 32'(nw), word});
        nw++;
        lane = 0;
      end else begin
        lane++;
      end
      send(d, bytes[i], last, gap);
    end
  endtask

  task automatic wait_done(input int d, input string tag);
    int n;
    n = 0;
    while (!dn[d] && n < 500) begin @(negedge clk); n++; end
    chk(tag, dn[d], 1'b1);
  endtask

  task automatic drain(input string tag);
    logic [65:0] e, a;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (act_q.size() > 0) a = act_q.pop_front();
      else a = '1;
      chk(tag, a, e);
    end
    chk({tag, "_extra"}, 66'(act_q.size()), 66'd0);
    act_q.delete();
  endtask

  initial begin
    logic [7:0] q[$];
    int n;
    rst = 1'b1;
    for (int d = 0; d < ND; d++) begin
      start[d] = 0; bv[d] = 0; bl[d] = 0; bd[d] = 0; delay[d] = 0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_ready", rdy[0], 1'b0);
    chk("rst_cs",    cs[0],  1'b0);
    chk("rst_we",    we[0],  1'b0);
    chk("rst_oe",    oe[0],  1'b0);
    chk("rst_busy",  busy[0], 1'b0);
    chk("rst_done",  dn[0],  1'b0);
    chk("rst_error", err[0], 1'b0);
    chk("rst_addr",  addr[0], 32'h0);
    chk("rst_data",  wdata[0], 32'h0);
    chk("rst_count", wc[0], 32'h0);
    chk("rst_addr_base", addr[2], 32'h10);

    // 8 bytes, immediate mem_done
    do_start(0);
    chk("t1_busy", busy[0], 1'b1);
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    load(0, q, 32'h0, 1024, 0, -1);
    wait_done(0, "t1_done");
    chk("t1_count", wc[0], 32'd2);
    chk("t1_error", err[0], 1'b0);
    chk("t1_busy_end", busy[0], 1'b0);
    chk("t1_word0", exp_q[0], {2'd0, 32'h0, 32'h04030201});
    chk("t1_word1", exp_q[1], {2'd0, 32'h1, 32'h08070605});
    drain("t1_ram");

    // short final word zero-filled
    do_start(0);
    chk("t2_done_clr", dn[0], 1'b0);
    q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    load(0, q, 32'h0, 1024, 0, -1);
    wait_done(0, "t2_done");
    chk("t2_count", wc[0], 32'd2);
    drain("t2_ram");

    // mem_done three cycles late
    delay[0] = 3;
    do_start(0);
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    load(0, q, 32'h0, 1024, 0, -1);
    n = 0;
    while (we[0] && n < 20) begin
      chk("t3_ready", rdy[0], 1'b0);
      chk("t3_data",  wdata[0], 32'h44332211);
      chk("t3_addr",  addr[0], 32'h0);
      n++;
      @(negedge clk);
    end
    chk("t3_we_cycles", 66'(n), 66'd4);
    wait_done(0, "t3_done");
    chk("t3_count", wc[0], 32'd1);
    drain("t3_ram");

    // capacity overflow
    do_start(1);
    q = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
          8'h38, 8'h39, 8'h3A, 8'h3B};
    load(1, q, 32'h0, 2, 0, -1);
    wait_done(1, "t4_done");
    chk("t4_error", err[1], 1'b1);
    chk("t4_count", wc[1], 32'd2);
    chk("t4_busy",  busy[1], 1'b0);
    drain("t4_ram");

    // offset base, throttled stream, start pulsed mid-load
    do_start(2);
    q = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57};
    load(2, q, 32'h10, 1024, 1, 3);
    wait_done(2, "t6_done");
    chk("t6_count", wc[2], 32'd2);
    chk("t6_error", err[2], 1'b0);
    drain("t6_ram");

    // reset while a write is pending
    delay[0] = 5;
    do_start(0);
    q = '{8'h61, 8'h62, 8'h63, 8'h64};
    load(0, q, 32'h0, 0, 0, -1);
    chk("t5_we_before", we[0], 1'b1);
    chk("t5_addr_before", addr[0], 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_we",    we[0],   1'b0);
    chk("t5_cs",    cs[0],   1'b0);
    chk("t5_addr",  addr[0], 32'h0);
    chk("t5_busy",  busy[0], 1'b0);
    chk("t5_ready", rdy[0],  1'b0);
    chk("t5_done",  dn[0],   1'b0);
    repeat (3) @(negedge clk);
    drain("t5_ram");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
